// File: rtl/spike_rate_decoder.sv
// Spike-train to 8-bit rate decoder: counts spikes over a programmable window of cycles.
// Sample appears the cycle after a window closes; counting never stalls, so an unconsumed sample is overwritten and flagged.
module spike_rate_decoder #(
  parameter int WIN_W   = 8,
  parameter int CNT_MAX = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             spike_in,
  input  logic [WIN_W-1:0] window_len,
  output logic [7:0]       rate_out,
  output logic             rate_valid,
  input  logic             rate_ready,
  output logic             overrun,
  input  logic             overrun_clr,
  output logic             win_done
);

  typedef enum logic {IDLE, COUNT} state_t;

  localparam logic [WIN_W-1:0] LEN_ONE = WIN_W'(1);
  localparam logic [7:0]       SAT     = 8'(CNT_MAX);

  state_t           state, state_nxt;
  logic [WIN_W-1:0] len_q;
  logic [WIN_W-1:0] win_cnt;
  logic [7:0]       cnt;
  logic [7:0]       cnt_final;
  logic [WIN_W-1:0] len_new;
  logic             start;
  logic             close;
  logic             last;
  logic             xfer;

  assign len_new   = (window_len == '0) ? LEN_ONE : window_len;
  assign last      = (win_cnt == (len_q - LEN_ONE));
  assign cnt_final = (spike_in && (cnt < SAT)) ? cnt + 8'd1 : cnt;
  assign xfer      = rate_valid && rate_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    close     = 1'b0;
    case (state)
      IDLE: begin
        if (enable) begin
          start     = 1'b1;
          state_nxt = COUNT;
        end
      end
      COUNT: begin
        if (!enable)   state_nxt = IDLE;
        else if (last) close     = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Window boundary re-latches the length so back-to-back windows have no gap cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      len_q   <= LEN_ONE;
      win_cnt <= '0;
      cnt     <= '0;
    end else if (start || close) begin
      len_q   <= len_new;
      win_cnt <= '0;
      cnt     <= '0;
    end else if (state == COUNT && enable) begin
      win_cnt <= win_cnt + LEN_ONE;
      cnt     <= cnt_final;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rate_out   <= '0;
      rate_valid <= 1'b0;
      overrun    <= 1'b0;
      win_done   <= 1'b0;
    end else begin
      win_done <= close;
      if (close) begin
        rate_out   <= cnt_final;
        rate_valid <= 1'b1;
      end else if (xfer) begin
        rate_valid <= 1'b0;
      end
      // Setting beats a coincident clear so no overwrite goes unreported.
      if (close && rate_valid && !rate_ready) overrun <= 1'b1;
      else if (overrun_clr)                   overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Directed bench for spike_rate_decoder with hand-computed expected samples.
module tb_spike_rate_decoder;

  localparam int WIN_W = 9;

  logic             clk = 1'b0;
  logic             rst;
  logic             enable;
  logic             spike_in;
  logic [WIN_W-1:0] window_len;
  logic [7:0]       rate_out;
  logic             rate_valid;
  logic             rate_ready;
  logic             overrun;
  logic             overrun_clr;
  logic             win_done;

  int total = 0;
  int bad   = 0;

  spike_rate_decoder #(.WIN_W(WIN_W), .CNT_MAX(255)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .spike_in   (spike_in),
    .window_len (window_len),
    .rate_out   (rate_out),
    .rate_valid (rate_valid),
    .rate_ready (rate_ready),
    .overrun    (overrun),
    .overrun_clr(overrun_clr),
    .win_done   (win_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [7:0] r, input logic v,
                         input logic o, input logic w);
    chk({tag, "_rate"},  {8'd0, rate_out}, {8'd0, r});
    chk({tag, "_valid"}, {15'd0, rate_valid}, {15'd0, v});
    chk({tag, "_ovr"},   {15'd0, overrun}, {15'd0, o});
    chk({tag, "_done"},  {15'd0, win_done}, {15'd0, w});
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; spike_in = 1'b0; window_len = '0;
    rate_ready = 1'b0; overrun_clr = 1'b0;
    tick();
    chk_out("reset", 8'd0, 1'b0, 1'b0, 1'b0);

    // Window of 10, spikes on cycles 2, 5, 7.
    rst = 1'b0; enable = 1'b1; window_len = 9'd10; rate_ready = 1'b1;
    tick();
    for (int c = 0; c < 10; c++) begin
      spike_in = (c == 2) || (c == 5) || (c == 7);
      tick();
      if (c < 9) chk("w10_pending", {15'd0, rate_valid}, 16'd0);
    end
    chk_out("w10_close", 8'd3, 1'b1, 1'b0, 1'b1);
    spike_in = 1'b0;
    tick();
    chk("w10_consumed_valid", {15'd0, rate_valid}, 16'd0);
    chk("w10_done_single", {15'd0, win_done}, 16'd0);

    // window_len=0 acts as 1: a sample every cycle, close and transfer coincide.
    enable = 1'b0;
    tick();
    window_len = 9'd0; spike_in = 1'b1; enable = 1'b1;
    tick();
    chk("w1_latch_valid", {15'd0, rate_valid}, 16'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_out("w1_every_cycle", 8'd1, 1'b1, 1'b0, 1'b1);
    end

    // 300 spikes in a 300-cycle window saturate at 255.
    enable = 1'b0;
    tick();
    chk("abort_consumes", {15'd0, rate_valid}, 16'd0);
    window_len = 9'd300; enable = 1'b1;
    tick();
    for (int c = 0; c < 299; c++) tick();
    chk("w300_pending", {15'd0, rate_valid}, 16'd0);
    tick();
    chk_out("w300_saturated", 8'd255, 1'b1, 1'b0, 1'b1);

    // No consumer: three windows of 4 with counts 2, 3, 1.
    enable = 1'b0;
    tick();
    rate_ready = 1'b0; window_len = 9'd4; spike_in = 1'b0; enable = 1'b1;
    tick();
    for (int c = 0; c < 4; c++) begin spike_in = (c < 2); tick(); end
    chk_out("ovr_w1", 8'd2, 1'b1, 1'b0, 1'b1);
    for (int c = 0; c < 4; c++) begin spike_in = (c < 3); tick(); end
    chk_out("ovr_w2", 8'd3, 1'b1, 1'b1, 1'b1);
    for (int c = 0; c < 4; c++) begin spike_in = (c == 3); tick(); end
    chk_out("ovr_w3", 8'd1, 1'b1, 1'b1, 1'b1);
    spike_in = 1'b0; overrun_clr = 1'b1;
    tick();
    chk_out("ovr_clr", 8'd1, 1'b1, 1'b0, 1'b0);
    overrun_clr = 1'b0;
    tick();
    tick();
    overrun_clr = 1'b1;
    tick();
    chk_out("ovr_set_wins", 8'd0, 1'b1, 1'b1, 1'b1);
    overrun_clr = 1'b0;

    // Abort after 3 spikes; only post-relatch spikes count.
    rate_ready = 1'b1; enable = 1'b0;
    tick();
    window_len = 9'd8; enable = 1'b1;
    tick();
    spike_in = 1'b1;
    tick(); tick(); tick();
    enable = 1'b0; spike_in = 1'b0;
    tick();
    chk("abort_valid", {15'd0, rate_valid}, 16'd0);
    chk("abort_done", {15'd0, win_done}, 16'd0);
    enable = 1'b1;
    tick();
    for (int c = 0; c < 8; c++) begin spike_in = (c == 1) || (c == 4); tick(); end
    chk_out("abort_relatch", 8'd2, 1'b1, 1'b1, 1'b1);

    // Reset mid-window with a pending sample and overrun set.
    rate_ready = 1'b0; spike_in = 1'b1;
    tick(); tick(); tick();
    chk("pre_rst_valid", {15'd0, rate_valid}, 16'd1);
    rst = 1'b1; window_len = 9'd1;
    tick();
    chk_out("mid_rst", 8'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    tick();
    chk("rst_idle_latch", {15'd0, rate_valid}, 16'd0);
    tick();
    chk_out("rst_first_win", 8'd1, 1'b1, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
